// File: rtl/dmux18_pkg.sv
// ============================================================================
// Module      : dmux18_pkg
// Description : Shared types and constants for the round-robin demux scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmux18_pkg;

    localparam int N_DEST = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_e;

endpackage

`default_nettype wire

// File: rtl/rr_pick8.sv
// ============================================================================
// Module      : rr_pick8
// Description : Combinational 8-way round-robin picker (rotate, encode, un-rotate).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick8
    import dmux18_pkg::*;
(
    input  logic [N_DEST-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  idx,
    output logic              any
);

    logic [N_DEST-1:0] w_rot;
    logic [SEL_W-1:0]  w_enc;

    // Rotating right by ptr puts the highest-priority requester at bit 0.
    assign w_rot = N_DEST'({req, req} >> ptr);

    always_comb begin
        w_enc = '0;
        for (int i = N_DEST - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_enc = SEL_W'(i);
            end
        end
    end

    assign idx = w_enc + ptr;
    assign any = |req;

endmodule

`default_nettype wire

// File: rtl/dmux18_rr_sched.sv
// ============================================================================
// Module      : dmux18_rr_sched
// Description : Round-robin burst scheduler driving a registered 1x8 demux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmux18_rr_sched
    import dmux18_pkg::*;
#(
    parameter int N_DEST = 8,
    parameter int BURST  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_DEST-1:0] req,
    input  logic              din_valid,
    input  logic              din,
    output logic              din_ready,
    output logic [SEL_W-1:0]  sel,
    output logic              en,
    output logic [N_DEST-1:0] y,
    output logic [N_DEST-1:0] gnt,
    output logic              done
);

    localparam int              CNT_W  = $clog2(BURST + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(BURST - 1);

    localparam logic [0:0] S_IDLE = ST_IDLE;
    localparam logic [0:0] S_XFER = ST_XFER;

    logic [0:0]        r_state;
    logic [SEL_W-1:0]  r_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic [SEL_W-1:0]  r_sel;
    logic              r_en;
    logic [N_DEST-1:0] r_y;
    logic [N_DEST-1:0] r_gnt;
    logic              r_done;
    logic              r_din_ready;

    logic [SEL_W-1:0]  w_idx;
    logic              w_any;
    logic              w_beat;
    logic              w_last;
    logic              w_req_sel;

    rr_pick8 u_pick (
        .req (req),
        .ptr (r_ptr),
        .idx (w_idx),
        .any (w_any)
    );

    assign w_beat    = din_valid & r_din_ready;
    assign w_last    = w_beat & (r_cnt == C_LAST);
    assign w_req_sel = req[r_sel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_sel       <= '0;
            r_en        <= 1'b0;
            r_y         <= '0;
            r_gnt       <= '0;
            r_done      <= 1'b0;
            r_din_ready <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_en   <= 1'b0;
            r_y    <= '0;
            r_done <= 1'b0;
            if (w_any) begin
                r_state     <= S_XFER;
                r_sel       <= w_idx;
                r_cnt       <= '0;
                r_gnt       <= N_DEST'(1) << w_idx;
                r_din_ready <= 1'b1;
            end
        end else begin
            if (w_beat) begin
                r_y   <= {{(N_DEST-1){1'b0}}, din} << r_sel;
                r_en  <= 1'b1;
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_y  <= '0;
                r_en <= 1'b0;
            end
            // Completion and abort share one exit; a final beat wins over a req drop.
            if (w_last || !w_req_sel) begin
                r_state     <= S_IDLE;
                r_done      <= 1'b1;
                r_ptr       <= r_sel + SEL_W'(1);
                r_cnt       <= '0;
                r_gnt       <= '0;
                r_din_ready <= 1'b0;
            end else begin
                r_done <= 1'b0;
            end
        end
    end

    assign din_ready = r_din_ready;
    assign sel       = r_sel;
    assign en        = r_en;
    assign y         = r_y;
    assign gnt       = r_gnt;
    assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_dmux18_rr_sched.sv
// ============================================================================
// Module      : tb_dmux18_rr_sched
// Description : Self-checking bench: vector table plus directed burst sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmux18_rr_sched;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       din_valid;
    logic       din;
    logic       din_ready;
    logic [2:0] sel;
    logic       en;
    logic [7:0] y;
    logic [7:0] gnt;
    logic       done;

    int checks;
    int errors;

    dmux18_rr_sched #(.N_DEST(8), .BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din_valid (din_valid),
        .din       (din),
        .din_ready (din_ready),
        .sel       (sel),
        .en        (en),
        .y         (y),
        .gnt       (gnt),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic       dv;
        logic       din;
        logic [2:0] sel;
        logic       en;
        logic [7:0] y;
        logic [7:0] gnt;
        logic       done;
        logic       rdy;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // One full grant: grant edge then four beats with din_valid held high.
    task automatic run_burst(input logic [2:0] exp_idx);
        logic b;
        step();
        chk($sformatf("burst%0d_sel", exp_idx), 32'(sel), 32'(exp_idx));
        chk($sformatf("burst%0d_gnt", exp_idx), 32'(gnt), 32'(8'h01 << exp_idx));
        chk($sformatf("burst%0d_rdy", exp_idx), 32'(din_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            b   = 1'($urandom_range(0, 1));
            din = b;
            step();
            chk($sformatf("burst%0d_en%0d", exp_idx, k), 32'(en), 32'd1);
            chk($sformatf("burst%0d_y%0d", exp_idx, k), 32'(y), 32'({7'd0, b} << exp_idx));
            chk($sformatf("burst%0d_done%0d", exp_idx, k), 32'(done), (k == 3) ? 32'd1 : 32'd0);
        end
        chk($sformatf("burst%0d_gnt_off", exp_idx), 32'(gnt), 32'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        req       = 8'h00;
        din_valid = 1'b0;
        din       = 1'b0;

        //            req    dv    din   sel   en    y      gnt    done  rdy
        vecs[0]  = '{8'h20, 1'b1, 1'b0, 3'd5, 1'b0, 8'h00, 8'h20, 1'b0, 1'b1};
        vecs[1]  = '{8'h20, 1'b1, 1'b1, 3'd5, 1'b1, 8'h20, 8'h20, 1'b0, 1'b1};
        vecs[2]  = '{8'h20, 1'b1, 1'b0, 3'd5, 1'b1, 8'h00, 8'h20, 1'b0, 1'b1};
        vecs[3]  = '{8'h20, 1'b1, 1'b1, 3'd5, 1'b1, 8'h20, 8'h20, 1'b0, 1'b1};
        vecs[4]  = '{8'h20, 1'b1, 1'b1, 3'd5, 1'b1, 8'h20, 8'h00, 1'b1, 1'b0};
        vecs[5]  = '{8'h00, 1'b0, 1'b0, 3'd5, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[6]  = '{8'h08, 1'b1, 1'b1, 3'd3, 1'b0, 8'h00, 8'h08, 1'b0, 1'b1};
        vecs[7]  = '{8'h08, 1'b1, 1'b1, 3'd3, 1'b1, 8'h08, 8'h08, 1'b0, 1'b1};
        vecs[8]  = '{8'h08, 1'b0, 1'b1, 3'd3, 1'b0, 8'h00, 8'h08, 1'b0, 1'b1};
        vecs[9]  = '{8'h08, 1'b1, 1'b0, 3'd3, 1'b1, 8'h00, 8'h08, 1'b0, 1'b1};
        vecs[10] = '{8'h08, 1'b0, 1'b1, 3'd3, 1'b0, 8'h00, 8'h08, 1'b0, 1'b1};
        vecs[11] = '{8'h08, 1'b1, 1'b1, 3'd3, 1'b1, 8'h08, 8'h08, 1'b0, 1'b1};
        vecs[12] = '{8'h08, 1'b0, 1'b1, 3'd3, 1'b0, 8'h00, 8'h08, 1'b0, 1'b1};
        vecs[13] = '{8'h08, 1'b1, 1'b1, 3'd3, 1'b1, 8'h08, 8'h00, 1'b1, 1'b0};
        vecs[14] = '{8'h00, 1'b0, 1'b0, 3'd3, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};

        step();
        step();
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rdy", 32'(din_ready), 32'd0);
        rst = 1'b0;

        // Single requester followed by a backpressured burst on destination 3.
        for (int i = 0; i < 15; i++) begin
            req       = vecs[i].req;
            din_valid = vecs[i].dv;
            din       = vecs[i].din;
            step();
            chk($sformatf("vec%0d_sel", i), 32'(sel), 32'(vecs[i].sel));
            chk($sformatf("vec%0d_en", i), 32'(en), 32'(vecs[i].en));
            chk($sformatf("vec%0d_y", i), 32'(y), 32'(vecs[i].y));
            chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].done));
            chk($sformatf("vec%0d_rdy", i), 32'(din_ready), 32'(vecs[i].rdy));
            if (i == 5) begin
                chk("single_ptr", 32'(dut.r_ptr), 32'd6);
            end
        end
        chk("bp_ptr", 32'(dut.r_ptr), 32'd4);

        // Fairness: all requesting, grants rotate 0..7 then back to 0.
        do_reset();
        req       = 8'hFF;
        din_valid = 1'b1;
        for (int g = 0; g < 9; g++) begin
            run_burst(3'(g % 8));
        end

        // Wrap-around from pointer 6 with requesters 6 and 0.
        do_reset();
        req = 8'h20;
        run_burst(3'd5);
        chk("wrap_ptr", 32'(dut.r_ptr), 32'd6);
        req = 8'h41;
        run_burst(3'd6);
        run_burst(3'd0);
        run_burst(3'd6);

        // Abort: request 3 dropped after two beats, third beat in the same cycle.
        do_reset();
        req = 8'h08;
        din = 1'b1;
        step();
        step();
        step();
        chk("abort_cnt", 32'(dut.r_cnt), 32'd2);
        req = 8'h00;
        step();
        chk("abort_done", 32'(done), 32'd1);
        chk("abort_gnt", 32'(gnt), 32'd0);
        chk("abort_rdy", 32'(din_ready), 32'd0);
        chk("abort_en", 32'(en), 32'd1);
        chk("abort_y", 32'(y), 32'h08);
        chk("abort_ptr", 32'(dut.r_ptr), 32'd4);
        req = 8'hFF;
        step();
        chk("abort_done_clr", 32'(done), 32'd0);
        chk("abort_next_sel", 32'(sel), 32'd4);
        chk("abort_next_gnt", 32'(gnt), 32'h10);

        // Asynchronous reset in the middle of a burst.
        req = 8'h88;
        step();
        step();
        step();
        chk("midrst_pre_gnt", 32'(gnt), 32'h80);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_sel", 32'(sel), 32'd0);
        chk("midrst_en", 32'(en), 32'd0);
        chk("midrst_y", 32'(y), 32'd0);
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_rdy", 32'(din_ready), 32'd0);
        step();
        rst = 1'b0;
        chk("midrst_ptr", 32'(dut.r_ptr), 32'd0);
        req = 8'hFF;
        step();
        chk("postrst_sel", 32'(sel), 32'd0);
        chk("postrst_gnt", 32'(gnt), 32'h01);
        chk("postrst_done", 32'(done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
